bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
Parametrised successor to the clock-face hour/minute counter. Holds time as packed BCD HH:MM[:SS] and advances on a single-cycle tick enable rather than a divided clock. Adds a configurable prescaler, optional seconds, 12/24-hour mode, validated parallel load, and carry pulses for alarm/snooze logic. Its outputs feed the display mux and the alarm comparator.

Parameters:
HAS_SEC, 1, 1 = seconds digits are counted; 0 = seconds are forced to 0 and minutes advance directly.
HOUR_MODE, 24, legal values 24 or 12; any other value is a synthesis-time error.
TICK_DIV, 1, number of tick pulses per least-significant time increment (range 1..65535).

Ports:
clk  in  1  system clock
reset_  in  1  synchronous, active-low reset
tick  in  1  one-cycle base-rate enable pulse
en  in  1  counting enable; when 0, ticks are ignored and the prescaler holds
load  in  1  one-cycle request to load ld_time / ld_pm
ld_time  in  24  BCD load value {h1,h0,m1,m0,s1,s0}, 4 bits per digit
ld_pm  in  1  PM flag for the load (12h mode only; ignored in 24h mode)
time_bcd  out  24  current time {h1,h0,m1,m0,s1,s0}
pm  out  1  PM flag (12h mode only; constant 0 in 24h mode)
min_carry  out  1  one-cycle pulse when minutes advance by counting
day_carry  out  1  one-cycle pulse on day wrap
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset_=0 sampled at posedge clk):
  - 24h mode: time_bcd = 00:00:00.
  - 12h mode: time_bcd = 12:00:00, pm = 0.
  - Prescaler = 0; min_carry, day_carry and load_err = 0.
  - Reset overrides load and tick in the same cycle.
- Prescaler:
  - When tick=1 and en=1, the prescaler increments.
  - When it reaches TICK_DIV-1 it wraps to 0 and generates an advance. TICK_DIV=1 means every enabled tick advances the time.
- Advance (registered; outputs change on the edge that samples the final tick, visible the cycle after tick):
  - Seconds count 00..59 in BCD (units 0-9, tens 0-5). 59 -> 00 carries into minutes.
  - Minutes count 00..59. Advancing minutes asserts min_carry for 1 cycle. 59 -> 00 carries into hours.
  - 24h hours: 00..23, then 23 -> 00 asserts day_carry.
  - 12h hours: sequence 12,01,02,..,11,12.
    - 11 -> 12 toggles pm.
    - The transition 11:59:59 PM -> 12:00:00 AM asserts day_carry.
  - HAS_SEC=0: s1/s0 read 0 and each advance increments minutes.
- Load validation (combinational check on ld_time):
  - Every digit must be <= 9.
  - m1 <= 5; s1 <= 5 when HAS_SEC=1 (seconds digits are ignored when HAS_SEC=0).
  - Hours must be 00..23 in 24h mode, or 01..12 in 12h mode.
- Load execution:
  - Valid load: time and pm update on the next edge, and the prescaler clears to 0.
  - Invalid load: time, pm and prescaler are unchanged; load_err pulses for 1 cycle.
  - No carry pulses are generated by a load.
- Simultaneous load and final tick in the same cycle: load wins and the advance is discarded. This applies to invalid loads too: the tick is still consumed and the prescaler clears only on a valid load.
- Pulse width: carry and load_err pulses are exactly 1 cycle and are never asserted during reset.
- en=0: the prescaler and time hold; load still works.
- tick held high continuously: counts once per clk (this supports fast-forward testing).

Decomposition:
- Shared package clock_pkg holds:
  - BCD digit width 4;
  - MAX_MIN_TENS=5, MAX_SEC_TENS=5;
  - hour limits H24_MAX=23, H12_MIN=1, H12_MAX=12;
  - the packed time field offsets.
- One natural sub-module, bcd_mod_digit_pair: a two-digit BCD counter with parametrised wrap value, inc input, wrap/carry output and synchronous load. It is instanced for seconds and minutes. Hours stay in the top because of the 12h special sequence.

Test Plan:
- Reset: reset_=0 for 2 cycles, HOUR_MODE=24 -> time_bcd=24'h000000; all pulses 0.
- TICK_DIV=4: 8 ticks from 00:00:00 -> 00:00:02; the change appears the cycle after the 4th and 8th ticks.
- Load 23:59:58 (24h), then 2 ticks (TICK_DIV=1) -> 23:59:59 then 00:00:00. min_carry and day_carry each pulse once, on the same cycle.
- HOUR_MODE=12: load 11:59:59 pm=0, tick -> 12:00:00 pm=1, no day_carry. Load 11:59:59 pm=1, tick -> 12:00:00 pm=0, day_carry=1.
- Invalid loads 24:00:00 (24h), 00:30:00 (12h) and 12:60:00 -> load_err pulses once each, time unchanged.
- Load asserted on the same cycle as the final tick with ld_time=08:15:00 -> 08:15:00, no min_carry, prescaler=0. With HAS_SEC=0, one tick from 08:15 -> 08:16, s1/s0 stay 0.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD digit, hour-limit and field-offset definitions for the time counter
package clock_pkg;

    localparam int DIGIT_W      = 4;
    localparam int MAX_MIN_TENS = 5;
    localparam int MAX_SEC_TENS = 5;
    localparam int H24_MAX      = 23;
    localparam int H12_MIN      = 1;
    localparam int H12_MAX      = 12;

    // Bit offsets of each digit inside the packed {h1,h0,m1,m0,s1,s0} word
    localparam int OFF_S0 = 0;
    localparam int OFF_S1 = 4;
    localparam int OFF_M0 = 8;
    localparam int OFF_M1 = 12;
    localparam int OFF_H0 = 16;
    localparam int OFF_H1 = 20;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t h1;
        bcd_digit_t h0;
        bcd_digit_t m1;
        bcd_digit_t m0;
        bcd_digit_t s1;
        bcd_digit_t s0;
    } bcd_time_t;

    // Binary value of a two-digit BCD field; only meaningful when both digits are <= 9
    function automatic logic [7:0] bcd_pair_to_bin(input bcd_digit_t tens, input bcd_digit_t units);
        return 8'(tens) * 8'd10 + 8'(units);
    endfunction

    // Plain BCD increment of a two-digit field with no wrap handling
    function automatic logic [7:0] bcd_pair_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_digit_pair.sv
// rtl/bcd_mod_digit_pair.sv - two-digit BCD modulo counter with synchronous load and wrap carry
module bcd_mod_digit_pair
    import clock_pkg::*;
#(
    parameter int MAX_TENS  = 5,
    parameter int MAX_UNITS = 9
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_inc,
    input  logic                 i_load,
    input  logic [2*DIGIT_W-1:0] i_ld_val,
    output logic [2*DIGIT_W-1:0] o_val,
    output logic                 o_carry
);

    localparam bcd_digit_t TENS_LIM  = bcd_digit_t'(MAX_TENS);
    localparam bcd_digit_t UNITS_LIM = bcd_digit_t'(MAX_UNITS);

    bcd_digit_t r_tens;
    bcd_digit_t r_units;
    logic       w_at_max;

    assign w_at_max = (r_tens == TENS_LIM) && (r_units == UNITS_LIM);
    // Carry is the increment that takes the pair from its wrap value back to 00
    assign o_carry  = i_inc && w_at_max;
    assign o_val    = {r_tens, r_units};

    // Load has priority over counting; counting wraps at the configured maximum
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (i_load) begin
            r_tens  <= i_ld_val[2*DIGIT_W-1:DIGIT_W];
            r_units <= i_ld_val[DIGIT_W-1:0];
        end else if (i_inc) begin
            if (w_at_max) begin
                r_tens  <= '0;
                r_units <= '0;
            end else if (r_units == 4'd9) begin
                r_units <= '0;
                r_tens  <= r_tens + 4'd1;
            end else begin
                r_units <= r_units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD HH:MM[:SS] time counter with prescaler, 12/24h mode and validated load
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int HAS_SEC   = 1,
    parameter int HOUR_MODE = 24,
    parameter int TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        tick,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] ld_time,
    input  logic        ld_pm,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        min_carry,
    output logic        day_carry,
    output logic        load_err
);

    generate
        if (HOUR_MODE != 24 && HOUR_MODE != 12) begin : g_bad_hour_mode
            $error("bcd_time_counter: HOUR_MODE must be 24 or 12");
        end
        if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_bad_tick_div
            $error("bcd_time_counter: TICK_DIV must be in 1..65535");
        end
    endgenerate

    localparam logic        IS_12H     = (HOUR_MODE == 12);
    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  HOUR_RESET = IS_12H ? 8'h12 : 8'h00;

    bcd_time_t   w_ld;
    logic [7:0]  w_ld_hbin;
    logic        w_digits_ok;
    logic        w_hour_ok;
    logic        w_ld_ok;
    logic        w_do_load;
    logic        w_tick_en;
    logic        w_final;
    logic        w_adv;
    logic        w_min_inc;
    logic        w_hour_inc;
    logic [7:0]  w_sec;
    logic [7:0]  w_min;
    logic [7:0]  w_hour_next;
    logic        w_pm_next;
    logic        w_day_wrap;

    logic [15:0] r_presc;
    logic [7:0]  r_hour;
    logic        r_pm;
    logic        r_min_carry;
    logic        r_day_carry;
    logic        r_load_err;

    // Load validation: every digit decimal, tens of minutes/seconds <= 5, hours in range for the mode
    assign w_ld        = ld_time;
    assign w_ld_hbin   = bcd_pair_to_bin(w_ld.h1, w_ld.h0);
    assign w_digits_ok = (w_ld.h1 <= 4'd9) && (w_ld.h0 <= 4'd9)
                      && (w_ld.m1 <= 4'(MAX_MIN_TENS)) && (w_ld.m0 <= 4'd9)
                      && ((HAS_SEC == 0) || ((w_ld.s1 <= 4'(MAX_SEC_TENS)) && (w_ld.s0 <= 4'd9)));
    assign w_hour_ok   = IS_12H ? ((w_ld_hbin >= 8'(H12_MIN)) && (w_ld_hbin <= 8'(H12_MAX)))
                                : (w_ld_hbin <= 8'(H24_MAX));
    assign w_ld_ok     = w_digits_ok && w_hour_ok;
    assign w_do_load   = load && w_ld_ok;

    // A load in the same cycle as the final tick swallows that advance
    assign w_tick_en = tick && en;
    assign w_final   = w_tick_en && (r_presc == PRESC_LAST);
    assign w_adv     = w_final && !load;

    // Prescaler: counts enabled ticks, wraps on the final one, clears on a valid load
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_presc <= '0;
        end else if (w_do_load) begin
            r_presc <= '0;
        end else if (w_tick_en) begin
            r_presc <= w_final ? 16'd0 : r_presc + 16'd1;
        end
    end

    generate
        if (HAS_SEC != 0) begin : g_sec
            logic w_sec_carry;
            bcd_mod_digit_pair #(
                .MAX_TENS  (MAX_SEC_TENS),
                .MAX_UNITS (9)
            ) u_sec (
                .i_clk     (clk),
                .i_reset_n (reset_),
                .i_inc     (w_adv),
                .i_load    (w_do_load),
                .i_ld_val  (ld_time[OFF_S0 +: 2*DIGIT_W]),
                .o_val     (w_sec),
                .o_carry   (w_sec_carry)
            );
            assign w_min_inc = w_sec_carry;
        end else begin : g_no_sec
            assign w_sec     = '0;
            assign w_min_inc = w_adv;
        end
    endgenerate

    bcd_mod_digit_pair #(
        .MAX_TENS  (MAX_MIN_TENS),
        .MAX_UNITS (9)
    ) u_min (
        .i_clk     (clk),
        .i_reset_n (reset_),
        .i_inc     (w_min_inc),
        .i_load    (w_do_load),
        .i_ld_val  (ld_time[OFF_M0 +: 2*DIGIT_W]),
        .o_val     (w_min),
        .o_carry   (w_hour_inc)
    );

    // Next hour: 00..23 in 24h mode; 12,01..11 in 12h mode with pm toggling on 11 -> 12
    always_comb begin
        w_hour_next = r_hour;
        w_pm_next   = r_pm;
        w_day_wrap  = 1'b0;
        if (IS_12H) begin
            if (r_hour == 8'h12) begin
                w_hour_next = 8'h01;
            end else if (r_hour == 8'h11) begin
                w_hour_next = 8'h12;
                w_pm_next   = !r_pm;
                w_day_wrap  = r_pm;
            end else begin
                w_hour_next = bcd_pair_inc(r_hour);
            end
        end else begin
            if (r_hour == 8'h23) begin
                w_hour_next = 8'h00;
                w_day_wrap  = 1'b1;
            end else begin
                w_hour_next = bcd_pair_inc(r_hour);
            end
        end
    end

    // Hour and pm registers: reset, load, or advance on minute wrap
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_hour <= HOUR_RESET;
            r_pm   <= 1'b0;
        end else if (w_do_load) begin
            r_hour <= ld_time[OFF_H0 +: 2*DIGIT_W];
            r_pm   <= IS_12H ? ld_pm : 1'b0;
        end else if (w_hour_inc) begin
            r_hour <= w_hour_next;
            r_pm   <= w_pm_next;
        end
    end

    // Single-cycle event pulses; counting is already blocked by any load
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_min_carry <= 1'b0;
            r_day_carry <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_min_carry <= w_min_inc;
            r_day_carry <= w_hour_inc && w_day_wrap;
            r_load_err  <= load && !w_ld_ok;
        end
    end

    assign time_bcd  = {r_hour, w_min, w_sec};
    assign pm        = r_pm;
    assign min_carry = r_min_carry;
    assign day_carry = r_day_carry;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - scoreboard bench for bcd_time_counter across four parameter sets
module tb_bcd_time_counter;

    typedef struct packed {
        logic [23:0] t;
        logic        pm;
        logic        mc;
        logic        dc;
        logic        le;
    } obs_t;

    typedef struct packed {
        logic [1:0]  d;
        logic        en;
        logic        tk;
        logic        ld;
        logic [23:0] v;
        logic        p;
        obs_t        e;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_;
    logic        tick;
    logic        en;
    logic        load;
    logic [23:0] ld_time;
    logic        ld_pm;

    logic [23:0] t_o  [4];
    logic        pm_o [4];
    logic        mc_o [4];
    logic        dc_o [4];
    logic        le_o [4];

    int   n_pass  = 0;
    int   n_total = 0;
    obs_t sb[$];

    // 0: 24h TICK_DIV=4, 1: 24h TICK_DIV=1, 2: 12h TICK_DIV=1, 3: 24h no seconds
    bcd_time_counter #(.HAS_SEC(1), .HOUR_MODE(24), .TICK_DIV(4)) u_d4 (
        .clk(clk), .reset_(reset_), .tick(tick), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
        .time_bcd(t_o[0]), .pm(pm_o[0]), .min_carry(mc_o[0]), .day_carry(dc_o[0]), .load_err(le_o[0]));
    bcd_time_counter #(.HAS_SEC(1), .HOUR_MODE(24), .TICK_DIV(1)) u_d1 (
        .clk(clk), .reset_(reset_), .tick(tick), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
        .time_bcd(t_o[1]), .pm(pm_o[1]), .min_carry(mc_o[1]), .day_carry(dc_o[1]), .load_err(le_o[1]));
    bcd_time_counter #(.HAS_SEC(1), .HOUR_MODE(12), .TICK_DIV(1)) u_h12 (
        .clk(clk), .reset_(reset_), .tick(tick), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
        .time_bcd(t_o[2]), .pm(pm_o[2]), .min_carry(mc_o[2]), .day_carry(dc_o[2]), .load_err(le_o[2]));
    bcd_time_counter #(.HAS_SEC(0), .HOUR_MODE(24), .TICK_DIV(1)) u_ns (
        .clk(clk), .reset_(reset_), .tick(tick), .en(en), .load(load), .ld_time(ld_time), .ld_pm(ld_pm),
        .time_bcd(t_o[3]), .pm(pm_o[3]), .min_carry(mc_o[3]), .day_carry(dc_o[3]), .load_err(le_o[3]));

    function automatic obs_t get_obs(input logic [1:0] d);
        obs_t o;
        o.t  = t_o[d];
        o.pm = pm_o[d];
        o.mc = mc_o[d];
        o.dc = dc_o[d];
        o.le = le_o[d];
        return o;
    endfunction

    function automatic step_t mk(input logic [1:0] d, input logic enb, input logic tk, input logic ld,
                                 input logic [23:0] v, input logic p, input logic [23:0] et,
                                 input logic epm, input logic emc, input logic edc, input logic ele);
        step_t s;
        s.d    = d;
        s.en   = enb;
        s.tk   = tk;
        s.ld   = ld;
        s.v    = v;
        s.p    = p;
        s.e.t  = et;
        s.e.pm = epm;
        s.e.mc = emc;
        s.e.dc = edc;
        s.e.le = ele;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_  = 1'b0;
        en      = 1'b1;
        tick    = 1'b1;
        load    = 1'b1;
        ld_time = 24'h123456;
        ld_pm   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_  = 1'b1;
        tick    = 1'b0;
        load    = 1'b0;
        ld_time = '0;
        ld_pm   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            e    = '0;
            e.t  = (d == 2) ? 24'h120000 : 24'h000000;
            o    = get_obs(2'(d));
            n_total++;
            if (o !== e)
                $display("FAIL reset[dut%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=0 pulses=0",
                         d, o.t, o.pm, o.mc, o.dc, o.le, e.t);
            else
                n_pass++;
        end
    endtask

    task automatic test_prescaler();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        do_reset();
        for (int k = 1; k <= 8; k++)
            st.push_back(mk(0, 1, 1, 0, 0, 0, (k < 4) ? 24'h0 : (k < 8) ? 24'h1 : 24'h2, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 24'h2, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) st.push_back(mk(0, 0, 1, 0, 0, 0, 24'h2, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h2, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h3, 0, 0, 0, 0));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL prescaler[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        en = 1'b1; tick = 1'b0; load = 1'b0;
    endtask

    task automatic test_rollover_24h();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        st.push_back(mk(1, 1, 0, 1, 24'h235958, 0, 24'h235958, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 1, 0, 0, 0, 24'h235959, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 1, 0, 0, 0, 24'h000000, 0, 1, 1, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 24'h000000, 0, 0, 0, 0));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL rollover_24h[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        tick = 1'b0; load = 1'b0;
    endtask

    task automatic test_12h();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        st.push_back(mk(2, 1, 0, 1, 24'h115959, 0, 24'h115959, 0, 0, 0, 0));
        st.push_back(mk(2, 1, 1, 0, 0, 0, 24'h120000, 1, 1, 0, 0));
        st.push_back(mk(2, 1, 0, 1, 24'h115959, 1, 24'h115959, 1, 0, 0, 0));
        st.push_back(mk(2, 1, 1, 0, 0, 0, 24'h120000, 0, 1, 1, 0));
        st.push_back(mk(2, 1, 0, 1, 24'h125959, 0, 24'h125959, 0, 0, 0, 0));
        st.push_back(mk(2, 1, 1, 0, 0, 0, 24'h010000, 0, 1, 0, 0));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL mode_12h[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        tick = 1'b0; load = 1'b0;
    endtask

    task automatic test_invalid_load();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        st.push_back(mk(1, 1, 0, 1, 24'h010203, 0, 24'h010203, 0, 0, 0, 0));
        st.push_back(mk(2, 1, 0, 0, 0, 0, 24'h010203, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 1, 24'h240000, 0, 24'h010203, 0, 0, 0, 1));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 24'h010203, 0, 0, 0, 0));
        st.push_back(mk(2, 1, 0, 1, 24'h003000, 0, 24'h010203, 0, 0, 0, 1));
        st.push_back(mk(1, 1, 0, 1, 24'h126000, 0, 24'h003000, 0, 0, 0, 1));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 24'h003000, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 1, 24'h1A0000, 0, 24'h003000, 0, 0, 0, 1));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL invalid_load[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        tick = 1'b0; load = 1'b0;
    endtask

    task automatic test_load_vs_tick();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        do_reset();
        for (int k = 0; k < 3; k++) st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h000000, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 1, 24'h081500, 0, 24'h081500, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h081500, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 1, 24'h081500, 0, 24'h081500, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h081500, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 0, 0, 0, 24'h081501, 0, 0, 0, 0));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL load_vs_tick[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        tick = 1'b0; load = 1'b0;
    endtask

    task automatic test_no_sec();
        step_t st[$];
        obs_t  o;
        obs_t  e;
        st.push_back(mk(3, 1, 0, 1, 24'h081559, 0, 24'h081500, 0, 0, 0, 0));
        st.push_back(mk(3, 1, 1, 0, 0, 0, 24'h081600, 0, 1, 0, 0));
        st.push_back(mk(3, 1, 1, 0, 0, 0, 24'h081700, 0, 1, 0, 0));
        st.push_back(mk(3, 1, 0, 0, 0, 0, 24'h081700, 0, 0, 0, 0));
        foreach (st[i]) begin
            en = st[i].en; tick = st[i].tk; load = st[i].ld; ld_time = st[i].v; ld_pm = st[i].p;
            sb.push_back(st[i].e);
            @(negedge clk);
            e = sb.pop_front();
            o = get_obs(st[i].d);
            n_total++;
            if (o !== e)
                $display("FAIL no_sec[%0d]: got t=%h pm=%b mc=%b dc=%b le=%b, want t=%h pm=%b mc=%b dc=%b le=%b",
                         i, o.t, o.pm, o.mc, o.dc, o.le, e.t, e.pm, e.mc, e.dc, e.le);
            else
                n_pass++;
        end
        tick = 1'b0; load = 1'b0;
    endtask

    initial begin
        reset_  = 1'b0;
        tick    = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        ld_time = '0;
        ld_pm   = 1'b0;
        test_reset();
        test_prescaler();
        test_rollover_24h();
        test_12h();
        test_invalid_load();
        test_load_vs_tick();
        test_no_sec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
